seq_player: RTL and testbench
=============================

Name: seq_player

Overview:
- Playback ("reader") side of the Simon Says sequence memory.
- On a start strobe, it snapshots the 32-bit packed colour word produced by MEM (16 steps × 2 bits).
- It then lights one of four LEDs per step with programmable on/gap timing, and reports busy/done/index to the game controller.
- It sits between MEM_OUT and the uo_out LED pins.

Parameters:
- ON_CYCLES, 4, clock cycles each step's LED is lit (≥1; production value set at top level from clock rate).
- GAP_CYCLES, 2, clock cycles all LEDs are dark after each step (≥1).
- CNT_W, 24, width of the internal timing counter; must hold max(ON_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock.
- rst_PLAY  input  1  synchronous, active-high reset.
- PLAY_START  input  1  single-cycle start strobe; sampled only in IDLE.
- PLAY_LEN  input  5  number of steps to play, 0..16; values >16 are clamped to 16.
- MEM_OUT  input  32  packed sequence; step i = MEM_OUT[2i+1:2i].
- PLAY_LED  output  4  one-hot LED drive; colour c lights bit c.
- PLAY_BUSY  output  1  high while a sequence is playing.
- PLAY_DONE  output  1  one-cycle pulse when playback completes.
- PLAY_IDX  output  4  index of the current step.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_PLAY is synchronous and active-high.
- Reset values: PLAY_LED=0, PLAY_BUSY=0, PLAY_DONE=0, PLAY_IDX=0, state=IDLE, counter=0, snapshot=0.
- Registered outputs: all outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: outputs idle. On PLAY_START=1 at edge t0:
    - latch snapshot<=MEM_OUT and len<=min(PLAY_LEN,16);
    - if len≠0, go to ON with idx=0, counter=ON_CYCLES-1;
    - if len=0, go to DONE.
  - ON: PLAY_LED = onehot(snapshot[2*idx+1:2*idx]), PLAY_BUSY=1. When counter=0, go to GAP with counter=GAP_CYCLES-1; otherwise decrement.
  - GAP: PLAY_LED=0, PLAY_BUSY=1. When counter=0:
    - if idx=len-1, go to DONE;
    - else idx<=idx+1, go to ON, counter=ON_CYCLES-1.
  - DONE: PLAY_DONE=1, PLAY_BUSY=0, PLAY_LED=0 for exactly one cycle, then IDLE. PLAY_IDX keeps the last step index until the next start.
- Timing for N≥1 steps:
  - PLAY_BUSY=1 in cycles t0+1 .. t0+N*(ON_CYCLES+GAP_CYCLES).
  - Step k is lit in cycles t0+1+k*(ON+GAP) .. t0+k*(ON+GAP)+ON.
  - PLAY_DONE pulses in cycle t0+N*(ON+GAP)+1.
- N=0: PLAY_DONE pulses at t0+1; PLAY_BUSY and PLAY_LED stay 0.
- Snapshot isolation: MEM_OUT changes during playback (e.g. MEM loading the next round) have no effect on the sequence being played.
- PLAY_START while BUSY or in DONE: ignored, no restart, no queuing.
- Reset mid-playback: at the edge where rst_PLAY=1, all outputs go to reset values on the next cycle. No DONE pulse is emitted. Reset dominates PLAY_START in the same cycle.
- Wrap: idx never exceeds 15; a len=16 sequence ends after step 15 without wrapping to 0.
- One-hot guarantee: PLAY_LED is never multi-hot in any cycle.

Test Plan:
- Basic 4-step playback: ON=4, GAP=2, MEM_OUT=32'h0000_00E4, PLAY_LEN=4, start at t0.
  - PLAY_LED = 0001, 0010, 0100, 1000, each for 4 cycles with 2 dark cycles between.
  - PLAY_BUSY high for 24 cycles; PLAY_DONE=1 only at t0+25.
  - PLAY_IDX steps 0→3.
- Zero length: PLAY_LEN=0, start → PLAY_DONE pulse at t0+1; PLAY_LED=0 and PLAY_BUSY=0 throughout.
- Clamp and full length: MEM_OUT=32'hFFFF_FFFF, PLAY_LEN=31.
  - Exactly 16 steps, PLAY_LED=1000 each step, PLAY_IDX reaches 15.
  - PLAY_DONE at t0+97.
- Snapshot isolation and start ignore: MEM_OUT=32'h0000_0001, PLAY_LEN=2, start.
  - At t0+3, change MEM_OUT to 32'h0000_000F and pulse PLAY_START.
  - Sequence remains 0010 then 0001; single DONE at t0+13; no restart.
- Reset mid-play: assert rst_PLAY for 1 cycle during step 1's ON phase.
  - Next cycle: PLAY_LED=0, PLAY_BUSY=0, PLAY_IDX=0; no PLAY_DONE.
  - A fresh start afterwards replays from step 0 correctly.
- Reset/start collision: rst_PLAY=1 and PLAY_START=1 in the same cycle → block stays in IDLE and PLAY_BUSY stays 0.

Source files
------------

// File: rtl/seq_player.sv
// Simon Says sequence playback: snapshots the packed colour word on start and
// lights one LED per step with programmable on/gap timing.
module seq_player #(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 24
) (
    input  logic        clk,
    input  logic        rst_PLAY,
    input  logic        PLAY_START,
    input  logic [4:0]  PLAY_LEN,
    input  logic [31:0] MEM_OUT,
    output logic [3:0]  PLAY_LED,
    output logic        PLAY_BUSY,
    output logic        PLAY_DONE,
    output logic [3:0]  PLAY_IDX
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       snap_q, snap_d;
    logic [4:0]        len_q, len_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        colour;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        len_d   = len_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (PLAY_START) begin
                    snap_d = MEM_OUT;
                    len_d  = (PLAY_LEN > 5'd16) ? 5'd16 : PLAY_LEN;
                    idx_d  = 4'd0;
                    if (len_d != 5'd0) begin
                        state_d = S_ON;
                        cnt_d   = ON_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    // len_q is at least 1 here, so len_q-1 cannot underflow
                    if ({1'b0, idx_q} == len_q - 5'd1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ON;
                        cnt_d   = ON_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state so they land in registers.
    assign colour = snap_d[{idx_d, 1'b0} +: 2];

    always_comb begin
        led_d  = 4'b0000;
        busy_d = (state_d == S_ON) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
        if (state_d == S_ON) begin
            unique case (colour)
                2'd0:    led_d = 4'b0001;
                2'd1:    led_d = 4'b0010;
                2'd2:    led_d = 4'b0100;
                default: led_d = 4'b1000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_PLAY) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign PLAY_LED  = led_q;
    assign PLAY_BUSY = busy_q;
    assign PLAY_DONE = done_q;
    assign PLAY_IDX  = idx_q;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: per-cycle comparison against a timeline model
// built from step count and on/gap durations.
module tb_seq_player;

    localparam int ON  = 4;
    localparam int GAP = 2;
    localparam int P   = ON + GAP;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic [31:0] mem;
    logic [3:0]  led;
    logic        busy;
    logic        done;
    logic [3:0]  idx;

    int vectors = 0;
    int miscompares = 0;

    seq_player #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .CNT_W     (24)
    ) dut (
        .clk       (clk),
        .rst_PLAY  (rst),
        .PLAY_START(start),
        .PLAY_LEN  (len),
        .MEM_OUT   (mem),
        .PLAY_LED  (led),
        .PLAY_BUSY (busy),
        .PLAY_DONE (done),
        .PLAY_IDX  (idx)
    );

    always #5 clk = ~clk;

    // Expected {led,busy,done,idx} in cycle c after the start edge (c>=1).
    function automatic logic [10:0] model(input logic [31:0] m,
                                          input int req, input int c);
        int n;
        int step;
        logic [1:0] col;
        logic [3:0] e_led;
        n = (req > 16) ? 16 : req;
        e_led = 4'b0000;
        if (n == 0)
            return {4'b0000, 1'b0, (c == 1), 4'd0};
        if (c <= n * P) begin
            step = (c - 1) / P;
            col  = m[2*step +: 2];
            if (((c - 1) % P) < ON)
                e_led = 4'(1 << col);
            return {e_led, 1'b1, 1'b0, 4'(step)};
        end
        return {4'b0000, 1'b0, (c == n * P + 1), 4'(n - 1)};
    endfunction

    function automatic int last_cycle(input int req);
        int n;
        n = (req > 16) ? 16 : req;
        return (n == 0) ? 1 : n * P + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start strobe; returns positioned in cycle t0+1.
    task automatic kick(input logic [31:0] m, input int req);
        mem   = m;
        len   = 5'(req);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({led, busy, done, idx} !== 11'd0) begin
            $display("FAIL reset: got %b required %b",
                     {led, busy, done, idx}, 11'd0);
            miscompares++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic(input logic [31:0] m, input int req,
                              input string name);
        logic [10:0] exp_v;
        int cend;
        cend = last_cycle(req) + 2;
        kick(m, req);
        for (int c = 1; c <= cend; c++) begin
            exp_v = model(m, req, c);
            vectors++;
            if ({led, busy, done, idx} !== exp_v) begin
                $display("FAIL %s c=%0d: got %b required %b",
                         name, c, {led, busy, done, idx}, exp_v);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_snapshot();
        logic [10:0] exp_v;
        kick(32'h0000_0001, 2);
        for (int c = 1; c <= 15; c++) begin
            exp_v = model(32'h0000_0001, 2, c);
            vectors++;
            if ({led, busy, done, idx} !== exp_v) begin
                $display("FAIL snapshot c=%0d: got %b required %b",
                         c, {led, busy, done, idx}, exp_v);
                miscompares++;
            end
            start = (c == 2);
            if (c == 2)
                mem = 32'h0000_000F;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp_v;
        logic [31:0] m;
        m = $urandom;
        kick(m, 4);
        for (int c = 1; c <= 8; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({led, busy, done, idx} !== 11'd0) begin
            $display("FAIL reset_mid: got %b required %b",
                     {led, busy, done, idx}, 11'd0);
            miscompares++;
        end
        for (int c = 0; c < 30; c++) begin
            vectors++;
            if ({busy, done} !== 2'b00) begin
                $display("FAIL reset_mid_quiet c=%0d: got %b required 00",
                         c, {busy, done});
                miscompares++;
            end
            tick();
        end
        m = $urandom;
        kick(m, 3);
        for (int c = 1; c <= last_cycle(3) + 1; c++) begin
            exp_v = model(m, 3, c);
            vectors++;
            if ({led, busy, done, idx} !== exp_v) begin
                $display("FAIL replay c=%0d: got %b required %b",
                         c, {led, busy, done, idx}, exp_v);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_collision();
        rst   = 1'b1;
        start = 1'b1;
        mem   = 32'hDEAD_BEEF;
        len   = 5'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({led, busy, done} !== 6'd0) begin
                $display("FAIL collision c=%0d: got %b required %b",
                         c, {led, busy, done}, 6'd0);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        logic [31:0] m;
        int req;
        int tl;
        for (int r = 0; r < 12; r++) begin
            m   = $urandom;
            req = (r % 4 == 0) ? $urandom_range(17, 31)
                               : $urandom_range(0, 16);
            tl  = last_cycle(req);
            kick(m, req);
            for (int c = 1; c <= tl + 2; c++) begin
                exp_v = model(m, req, c);
                vectors++;
                if ({led, busy, done, idx} !== exp_v) begin
                    $display("FAIL random r=%0d c=%0d: got %b required %b",
                             r, c, {led, busy, done, idx}, exp_v);
                    miscompares++;
                end
                start = (c <= tl) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem   = $urandom;
                len   = 5'($urandom);
                tick();
            end
            start = 1'b0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = 5'd0;
        mem   = 32'd0;
        test_reset();
        test_basic(32'h0000_00E4, 4, "basic");
        test_basic(32'h0000_0000, 0, "zero_len");
        test_basic(32'hFFFF_FFFF, 31, "clamp");
        test_snapshot();
        test_reset_mid();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
